// File: rtl/da_bitplane_sequencer.sv
// Bit-plane sequencer for the distributed-arithmetic LUT/SA datapath.
// Streams one activation bit-plane per cycle, LSB first, then waits for the pipe to drain.
module da_bitplane_sequencer #(
  parameter int DATA_WIDTH_A = 16,
  parameter int K            = 9,
  parameter int PIPE_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [K*DATA_WIDTH_A-1:0] A_vec,
  input  logic                      abort,
  output logic                      gen_done,
  output logic                      A0,
  output logic [K-2:0]              addr_array,
  output logic [7:0]                t,
  output logic                      acc_clr,
  output logic                      acc_last,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready
);

  localparam int W  = DATA_WIDTH_A;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [7:0] T_LAST = 8'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    WAIT_OUT
  } state_t;

  state_t         state;
  logic [W-1:0]   sr [K];
  logic [CW-1:0]  cnt;
  logic           to_idle;

  // abort only cancels work that has not yet produced a result
  assign to_idle = rst |
    (abort & ((state == RUN) | (state == DRAIN)));

  always_ff @(posedge clk) begin
    if (to_idle) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
      A0         <= 1'b0;
      addr_array <= '0;
      t          <= '0;
      acc_clr    <= 1'b0;
      acc_last   <= 1'b0;
      res_valid  <= 1'b0;
      cnt        <= '0;
      for (int i = 0; i < K; i++)
        sr[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            gen_done <= 1'b1;
            acc_clr  <= 1'b1;
            acc_last <= 1'b0;
            t        <= '0;
            // plane 0 goes straight to the output registers
            A0 <= A_vec[0];
            for (int j = 0; j < K-1; j++)
              addr_array[j] <= A_vec[(j+1)*W];
            for (int i = 0; i < K; i++)
              sr[i] <= A_vec[i*W +: W] >> 1;
          end
        end
        RUN: begin
          if (t == T_LAST) begin
            state      <= (PIPE_LAT == 0) ? WAIT_OUT : DRAIN;
            res_valid  <= (PIPE_LAT == 0);
            gen_done   <= 1'b0;
            A0         <= 1'b0;
            addr_array <= '0;
            acc_clr    <= 1'b0;
            acc_last   <= 1'b0;
            cnt        <= '0;
          end else begin
            t        <= t + 8'd1;
            acc_clr  <= 1'b0;
            acc_last <= ((t + 8'd1) == T_LAST);
            A0       <= sr[0][0];
            for (int j = 0; j < K-1; j++)
              addr_array[j] <= sr[j+1][0];
            for (int i = 0; i < K; i++)
              sr[i] <= sr[i] >> 1;
          end
        end
        DRAIN: begin
          if (cnt == CNT_LAST) begin
            state     <= WAIT_OUT;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            t         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_bitplane_sequencer.sv
// Randomized bench for da_bitplane_sequencer, checked against a per-vector
// timeline model (planes, drain, result handshake) derived from the block's rules.
module tb_da_bitplane_sequencer;

  localparam int K = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv0 = 1'b0;
  logic iv1 = 1'b0;
  logic abort = 1'b0;
  logic res_ready = 1'b0;
  logic [K*16-1:0] av0 = '0;
  logic [K*4-1:0]  av1 = '0;

  logic ir0, gd0, a00, clr0, last0, busy0, rv0;
  logic ir1, gd1, a01, clr1, last1, busy1, rv1;
  logic [7:0] ad0, ad1, t0, t1;

  da_bitplane_sequencer #(
    .DATA_WIDTH_A(16), .K(K), .PIPE_LAT(1)
  ) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .A_vec(av0), .abort(abort), .gen_done(gd0), .A0(a00),
    .addr_array(ad0), .t(t0), .acc_clr(clr0), .acc_last(last0),
    .busy(busy0), .res_valid(rv0), .res_ready(res_ready)
  );

  da_bitplane_sequencer #(
    .DATA_WIDTH_A(4), .K(K), .PIPE_LAT(0)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .A_vec(av1), .abort(abort), .gen_done(gd1), .A0(a01),
    .addr_array(ad1), .t(t1), .acc_clr(clr1), .acc_last(last1),
    .busy(busy1), .res_valid(rv1), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int sel = 0;
  int cw = 16;
  int cpl = 1;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] a [K];

  logic o_ir, o_gd, o_a0, o_clr, o_last, o_busy, o_rv;
  logic [7:0] o_ad, o_t;

  always_comb begin
    o_ir   = sel ? ir1   : ir0;
    o_gd   = sel ? gd1   : gd0;
    o_a0   = sel ? a01   : a00;
    o_clr  = sel ? clr1  : clr0;
    o_last = sel ? last1 : last0;
    o_busy = sel ? busy1 : busy0;
    o_rv   = sel ? rv1   : rv0;
    o_ad   = sel ? ad1   : ad0;
    o_t    = sel ? t1    : t0;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] plane(input int p);
    logic [7:0] r;
    for (int j = 0; j < K-1; j++)
      r[j] = a[j+1][p];
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_in_ready"}, o_ir, 1);
    check({tag, "_gen_done"}, o_gd, 0);
    check({tag, "_A0"}, o_a0, 0);
    check({tag, "_addr"}, o_ad, 0);
    check({tag, "_t"}, o_t, 0);
    check({tag, "_acc_clr"}, o_clr, 0);
    check({tag, "_acc_last"}, o_last, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_res_valid"}, o_rv, 0);
  endtask

  task automatic set_iv(input logic v);
    if (sel != 0) iv1 = v;
    else iv0 = v;
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < K; i++) begin
      av0[i*16 +: 16] = 16'($urandom);
      av1[i*4 +: 4]   = 4'($urandom);
    end
  endtask

  // mode: 0 normal, 1 abort at plane `at`, 2 reset at plane `at`, 3 abort in drain
  task automatic run_vec(input int mode, input int at, input int hold);
    for (int i = 0; i < K; i++) begin
      av0[i*16 +: 16] = a[i];
      av1[i*4 +: 4]   = a[i][3:0];
    end
    check("accept_ready", o_ir, 1);
    set_iv(1'b1);
    step();
    set_iv(1'b0);
    for (int p = 0; p < cw; p++) begin
      scramble_bus();
      set_iv(1'($urandom));
      check("run_gen_done", o_gd, 1);
      check("run_t", o_t, p);
      check("run_A0", o_a0, a[0][p]);
      check("run_addr", o_ad, plane(p));
      check("run_acc_clr", o_clr, (p == 0));
      check("run_acc_last", o_last, (p == cw-1));
      check("run_busy", o_busy, 1);
      check("run_in_ready", o_ir, 0);
      check("run_res_valid", o_rv, 0);
      if ((mode == 1 || mode == 2) && p == at) begin
        set_iv(1'b0);
        if (mode == 1) abort = 1'b1;
        else rst = 1'b1;
        step();
        abort = 1'b0;
        rst = 1'b0;
        chk_idle(mode == 1 ? "abort" : "rst");
        return;
      end
      step();
    end
    set_iv(1'b0);
    for (int d = 0; d < cpl; d++) begin
      check("drain_gen_done", o_gd, 0);
      check("drain_A0", o_a0, 0);
      check("drain_addr", o_ad, 0);
      check("drain_t", o_t, cw-1);
      check("drain_busy", o_busy, 1);
      check("drain_res_valid", o_rv, 0);
      if (mode == 3) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("drain_abort");
        return;
      end
      step();
    end
    for (int h = 0; h < hold; h++) begin
      check("wait_res_valid", o_rv, 1);
      check("wait_in_ready", o_ir, 0);
      check("wait_gen_done", o_gd, 0);
      abort = 1'($urandom);
      step();
    end
    check("hs_res_valid", o_rv, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    abort = 1'b0;
    check("post_res_valid", o_rv, 0);
    check("post_in_ready", o_ir, 1);
    check("post_busy", o_busy, 0);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < K; i++)
      a[i] = 16'($urandom);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++)
      chk_idle("reset");

    a[0] = 16'h8001;
    for (int j = 1; j < K; j++)
      a[j] = 16'(1 << (j-1));
    run_vec(0, 0, 5);
    rand_vec();
    run_vec(0, 0, 0);
    rand_vec();
    run_vec(1, 7, 0);
    rand_vec();
    run_vec(0, 0, 3);
    rand_vec();
    run_vec(2, 4, 0);
    rand_vec();
    run_vec(0, 0, 1);
    rand_vec();
    run_vec(1, 15, 0);
    rand_vec();
    run_vec(3, 0, 0);
    for (int n = 0; n < 20; n++) begin
      rand_vec();
      run_vec(int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 6)));
    end

    sel = 1;
    cw = 4;
    cpl = 0;
    chk_idle("idle1");
    for (int i = 0; i < K; i++)
      a[i] = 16'hffff;
    run_vec(0, 0, 2);
    for (int n = 0; n < 12; n++) begin
      rand_vec();
      run_vec(int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
